// File: rtl/fpu_issue_scheduler.sv
// FPU issue scheduler: scoreboard, writeback reservation and divider occupancy.
// Issues one decoded FP instruction per cycle when no hazard is present.
module fpu_issue_scheduler #(
    parameter int ASIZE   = 5,
    parameter int NREG    = 32,
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       in_flags,
    input  logic [ASIZE-1:0] in_rs,
    input  logic [ASIZE-1:0] in_rt,
    input  logic [ASIZE-1:0] in_rd,
    output logic             in_ready,
    output logic             issue_valid,
    output logic [1:0]       issue_unit,
    output logic             issue_sub,
    output logic [ASIZE-1:0] issue_rd,
    output logic             wb_valid,
    output logic [ASIZE-1:0] wb_rd,
    output logic             div_busy,
    output logic             err_illegal
);

    localparam int CW = $clog2(DIV_LAT + 1);

    logic [NREG-1:0]                 pending_q, pending_d;
    logic [DIV_LAT-1:0]              res_v_q, res_v_d;
    logic [DIV_LAT-1:0][ASIZE-1:0]   res_rd_q, res_rd_d;
    logic [CW-1:0]                   div_cnt_q, div_cnt_d;
    logic                            iss_v_q, iss_v_d;
    logic [1:0]                      iss_unit_q, iss_unit_d;
    logic                            iss_sub_q, iss_sub_d;
    logic [ASIZE-1:0]                iss_rd_q, iss_rd_d;
    logic                            err_q, err_d;

    logic             legal;
    logic             is_mul;
    logic             is_div;
    logic [DIV_LAT:0] res_pad;
    logic             data_haz;
    logic             wb_conf;
    logic             struct_haz;
    logic             acc;
    logic             acc_ok;

    assign legal  = (in_flags != 4'd0) &&
                    ((in_flags & (in_flags - 4'd1)) == 4'd0);
    assign is_mul = in_flags[2];
    assign is_div = in_flags[3];

    // Index L of the padded vector is the slot that would emit in t+L.
    assign res_pad = {1'b0, res_v_q};

    assign data_haz   = pending_q[in_rs] | pending_q[in_rt] | pending_q[in_rd];
    assign wb_conf    = is_div ? res_pad[DIV_LAT] :
                        is_mul ? res_pad[MUL_LAT] : res_pad[ADD_LAT];
    assign struct_haz = is_div & div_busy;

    assign in_ready = rst_n & (~legal | ~(data_haz | wb_conf | struct_haz));
    assign acc      = in_valid & in_ready;
    assign acc_ok   = acc & legal;

    always_comb begin
        pending_d  = pending_q;
        res_v_d    = '0;
        res_rd_d   = '0;
        div_cnt_d  = div_cnt_q;
        iss_v_d    = 1'b0;
        iss_unit_d = 2'd0;
        iss_sub_d  = 1'b0;
        iss_rd_d   = '0;
        err_d      = acc & ~legal;

        for (int i = 0; i < DIV_LAT - 1; i++) begin
            res_v_d[i]  = res_v_q[i+1];
            res_rd_d[i] = res_rd_q[i+1];
        end

        if (div_cnt_q != '0)
            div_cnt_d = div_cnt_q - CW'(1);

        if (res_v_q[0])
            pending_d[res_rd_q[0]] = 1'b0;

        if (acc_ok) begin
            pending_d[in_rd] = 1'b1;
            iss_v_d  = 1'b1;
            iss_rd_d = in_rd;
            unique case (1'b1)
                is_div: begin
                    iss_unit_d           = 2'd2;
                    div_cnt_d            = CW'(DIV_LAT);
                    res_v_d[DIV_LAT-1]   = 1'b1;
                    res_rd_d[DIV_LAT-1]  = in_rd;
                end
                is_mul: begin
                    iss_unit_d           = 2'd1;
                    res_v_d[MUL_LAT-1]   = 1'b1;
                    res_rd_d[MUL_LAT-1]  = in_rd;
                end
                default: begin
                    iss_sub_d            = in_flags[1];
                    res_v_d[ADD_LAT-1]   = 1'b1;
                    res_rd_d[ADD_LAT-1]  = in_rd;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            res_v_q    <= '0;
            res_rd_q   <= '0;
            div_cnt_q  <= '0;
            iss_v_q    <= 1'b0;
            iss_unit_q <= 2'd0;
            iss_sub_q  <= 1'b0;
            iss_rd_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            res_v_q    <= res_v_d;
            res_rd_q   <= res_rd_d;
            div_cnt_q  <= div_cnt_d;
            iss_v_q    <= iss_v_d;
            iss_unit_q <= iss_unit_d;
            iss_sub_q  <= iss_sub_d;
            iss_rd_q   <= iss_rd_d;
            err_q      <= err_d;
        end
    end

    assign issue_valid = iss_v_q;
    assign issue_unit  = iss_unit_q;
    assign issue_sub   = iss_sub_q;
    assign issue_rd    = iss_rd_q;
    assign wb_valid    = res_v_q[0];
    assign wb_rd       = res_v_q[0] ? res_rd_q[0] : '0;
    assign div_busy    = (div_cnt_q != '0);
    assign err_illegal = err_q;

endmodule

// File: tb/tb_fpu_issue_scheduler.sv
// Bench for fpu_issue_scheduler: directed scenarios then random traffic,
// checked against a cycle-indexed reference model.
module tb_fpu_issue_scheduler;

    localparam int AW = 5;
    localparam int NR = 32;
    localparam int DL = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [3:0]    in_flags;
    logic [AW-1:0] in_rs, in_rt, in_rd;
    logic          in_ready, issue_valid, issue_sub;
    logic [1:0]    issue_unit;
    logic [AW-1:0] issue_rd, wb_rd;
    logic          wb_valid, div_busy, err_illegal;

    fpu_issue_scheduler dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_flags(in_flags),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_ready(in_ready),
        .issue_valid(issue_valid), .issue_unit(issue_unit),
        .issue_sub(issue_sub), .issue_rd(issue_rd), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .div_busy(div_busy), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: absolute cycle numbers for every future event.
    int cyc;
    int reg_until[NR];
    int wb_map[int];
    int div_until;
    logic       nxt_iv, nxt_sub, nxt_err;
    logic [1:0] nxt_unit;
    logic [4:0] nxt_rd;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input logic [3:0] f);
        if (f[3]) return DL;
        if (f[2]) return 3;
        return 2;
    endfunction

    task automatic model_clear();
        wb_map.delete();
        for (int i = 0; i < NR; i++) reg_until[i] = -1;
        div_until = -1;
        nxt_iv = 0; nxt_sub = 0; nxt_err = 0; nxt_unit = 0; nxt_rd = 0;
    endtask

    task automatic step(input logic v, input logic [3:0] f,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, output logic acc);
        logic       c_iv, c_sub, c_err, ewb, er, lg;
        logic [1:0] c_unit;
        logic [4:0] c_rd, ewr;
        int         L;
        @(negedge clk);
        cyc++;
        c_iv = nxt_iv; c_sub = nxt_sub; c_err = nxt_err;
        c_unit = nxt_unit; c_rd = nxt_rd;
        nxt_iv = 0; nxt_sub = 0; nxt_err = 0; nxt_unit = 0; nxt_rd = 0;
        check("issue_valid", 32'(issue_valid), 32'(c_iv));
        check("issue_unit", 32'(issue_unit), 32'(c_unit));
        check("issue_sub", 32'(issue_sub), 32'(c_sub));
        check("issue_rd", 32'(issue_rd), 32'(c_rd));
        check("err_illegal", 32'(err_illegal), 32'(c_err));
        ewb = 0; ewr = 0;
        if (wb_map.exists(cyc)) begin
            ewb = 1; ewr = 5'(wb_map[cyc]); wb_map.delete(cyc);
        end
        check("wb_valid", 32'(wb_valid), 32'(ewb));
        check("wb_rd", 32'(wb_rd), 32'(ewr));
        check("div_busy", 32'(div_busy), 32'(cyc <= div_until));
        rst_n = 1'b1;
        in_valid = v; in_flags = f; in_rs = rs; in_rt = rt; in_rd = rd;
        #1;
        lg = ($countones(f) == 1);
        L  = lat_of(f);
        if (!lg) er = 1;
        else er = !(reg_until[rs] >= cyc || reg_until[rt] >= cyc ||
                    reg_until[rd] >= cyc || wb_map.exists(cyc + L) ||
                    (f[3] && cyc <= div_until));
        check("in_ready", 32'(in_ready), 32'(er));
        acc = v && er;
        if (acc && lg) begin
            reg_until[rd] = cyc + L;
            wb_map[cyc + L] = rd;
            nxt_iv = 1; nxt_rd = rd; nxt_sub = f[1];
            nxt_unit = f[3] ? 2'd2 : (f[2] ? 2'd1 : 2'd0);
            if (f[3]) div_until = cyc + DL;
        end else if (acc) begin
            nxt_err = 1;
        end
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(0, 4'd0, 0, 0, 0, a);
    endtask

    task automatic present(input logic [3:0] f, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd,
                           output int waited);
        logic a;
        waited = 0;
        step(1, f, rs, rt, rd, a);
        while (!a && waited < 40) begin
            waited++;
            step(1, f, rs, rt, rd, a);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_issue_valid"}, 32'(issue_valid), 0);
        check({tag, "_issue_unit"}, 32'(issue_unit), 0);
        check({tag, "_issue_sub"}, 32'(issue_sub), 0);
        check({tag, "_issue_rd"}, 32'(issue_rd), 0);
        check({tag, "_wb_valid"}, 32'(wb_valid), 0);
        check({tag, "_wb_rd"}, 32'(wb_rd), 0);
        check({tag, "_div_busy"}, 32'(div_busy), 0);
        check({tag, "_err"}, 32'(err_illegal), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        cyc++;
        rst_n = 1'b0;
        in_valid = 1; in_flags = 4'b0001; in_rs = 0; in_rt = 0; in_rd = 0;
        #1;
        check_zero("rst");
        model_clear();
        for (int i = 1; i < ncyc; i++) begin
            @(negedge clk);
            cyc++;
            #1;
            check_zero("rst_hold");
        end
    endtask

    initial begin
        int   w;
        logic a;
        logic [3:0] f;
        rst_n = 1'b0;
        in_valid = 1; in_flags = 4'b0001; in_rs = 0; in_rt = 0; in_rd = 0;
        cyc = -1;
        model_clear();
        #7;
        check_zero("por");

        // Add then issue/wb checks; first accept right after reset.
        present(4'b0001, 6, 10, 4, w);
        check("add_first_wait", 32'(w), 0);
        idle(12);

        // RAW on rd=4: blocked two cycles.
        present(4'b0001, 6, 10, 4, w);
        present(4'b0100, 4, 7, 9, w);
        check("raw_wait", 32'(w), 2);
        idle(12);

        // Writeback slot conflict: mul then add.
        present(4'b0100, 1, 2, 3, w);
        present(4'b0001, 5, 6, 7, w);
        check("wbconf_wait", 32'(w), 1);
        idle(12);

        // Divider occupancy.
        present(4'b1000, 5, 6, 1, w);
        present(4'b1000, 7, 8, 2, w);
        check("div_wait", 32'(w), 8);
        idle(20);

        // Illegal flags consumed, scoreboard untouched.
        step(1, 4'b0011, 1, 2, 3, a);
        check("illegal_acc", 32'(a), 1);
        present(4'b0010, 1, 2, 3, w);
        check("after_illegal_wait", 32'(w), 0);
        step(1, 4'b0000, 0, 0, 0, a);
        check("zero_flags_acc", 32'(a), 1);
        idle(12);

        // Reset while a div is in flight.
        present(4'b1000, 5, 6, 1, w);
        idle(3);
        do_reset(2);
        present(4'b1000, 5, 6, 3, w);
        check("post_reset_div_wait", 32'(w), 0);
        idle(20);

        // Random traffic on a small register window to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 8) f = 4'(1 << $urandom_range(0, 3));
            else f = 4'($urandom_range(0, 15));
            step($urandom_range(0, 3) != 0, f,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), a);
            if (i == 300) do_reset(1 + $urandom_range(0, 2));
        end
        idle(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
